// File: rtl/fft_4_stream_ctrl.sv
// Framed 4-point FFT sequencer: loads four complex samples over a valid/ready
// stream, evaluates them on a combinational fft_4 core and unloads bins y1..y4.

module fft_4 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] x1_r,
    input  logic [DATA_WIDTH-1:0] x1_i,
    input  logic [DATA_WIDTH-1:0] x2_r,
    input  logic [DATA_WIDTH-1:0] x2_i,
    input  logic [DATA_WIDTH-1:0] x3_r,
    input  logic [DATA_WIDTH-1:0] x3_i,
    input  logic [DATA_WIDTH-1:0] x4_r,
    input  logic [DATA_WIDTH-1:0] x4_i,
    output logic [DATA_WIDTH-1:0] y1_r,
    output logic [DATA_WIDTH-1:0] y1_i,
    output logic [DATA_WIDTH-1:0] y2_r,
    output logic [DATA_WIDTH-1:0] y2_i,
    output logic [DATA_WIDTH-1:0] y3_r,
    output logic [DATA_WIDTH-1:0] y3_i,
    output logic [DATA_WIDTH-1:0] y4_r,
    output logic [DATA_WIDTH-1:0] y4_i
);
    logic [DATA_WIDTH-1:0] w_s13_r, w_s13_i, w_d13_r, w_d13_i;
    logic [DATA_WIDTH-1:0] w_s24_r, w_s24_i, w_d24_r, w_d24_i;

    assign w_s13_r = x1_r + x3_r;
    assign w_s13_i = x1_i + x3_i;
    assign w_d13_r = x1_r - x3_r;
    assign w_d13_i = x1_i - x3_i;
    assign w_s24_r = x2_r + x4_r;
    assign w_s24_i = x2_i + x4_i;
    assign w_d24_r = x2_r - x4_r;
    assign w_d24_i = x2_i - x4_i;

    // Multiplying by -j maps (a + jb) to (b - ja); all sums wrap naturally.
    assign y1_r = w_s13_r + w_s24_r;
    assign y1_i = w_s13_i + w_s24_i;
    assign y2_r = w_d13_r + w_d24_i;
    assign y2_i = w_d13_i - w_d24_r;
    assign y3_r = w_s13_r - w_s24_r;
    assign y3_i = w_s13_i - w_s24_i;
    assign y4_r = w_d13_r - w_d24_i;
    assign y4_i = w_d13_i + w_d24_r;
endmodule

module fft_4_stream_ctrl #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_cnt, r_idx;
    logic [15:0]           r_frame_cnt;
    logic [DATA_WIDTH-1:0] r_x_r [4];
    logic [DATA_WIDTH-1:0] r_x_i [4];
    logic [DATA_WIDTH-1:0] r_y_r [4];
    logic [DATA_WIDTH-1:0] r_y_i [4];
    logic [DATA_WIDTH-1:0] w_y_r [4];
    logic [DATA_WIDTH-1:0] w_y_i [4];
    logic                  w_in_hs, w_out_hs;

    // A handshake coinciding with flush is dropped on the input side.
    assign w_in_hs  = in_valid && (r_state == ST_LOAD) && !flush;
    assign w_out_hs = out_ready && (r_state == ST_UNLOAD);

    fft_4 #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .x1_r(r_x_r[0]), .x1_i(r_x_i[0]),
        .x2_r(r_x_r[1]), .x2_i(r_x_i[1]),
        .x3_r(r_x_r[2]), .x3_i(r_x_i[2]),
        .x4_r(r_x_r[3]), .x4_i(r_x_i[3]),
        .y1_r(w_y_r[0]), .y1_i(w_y_i[0]),
        .y2_r(w_y_r[1]), .y2_i(w_y_i[1]),
        .y3_r(w_y_r[2]), .y3_i(w_y_i[2]),
        .y4_r(w_y_r[3]), .y4_i(w_y_i[3])
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_LOAD;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_hs && (r_cnt == 2'd3)) w_state_nxt = ST_COMPUTE;
                    else                            w_state_nxt = ST_LOAD;
                end
                ST_COMPUTE: w_state_nxt = ST_UNLOAD;
                ST_UNLOAD: begin
                    if (w_out_hs && (r_idx == 2'd3)) w_state_nxt = ST_LOAD;
                    else                             w_state_nxt = ST_UNLOAD;
                end
                default: w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Load/unload counters and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 2'd0;
            r_idx       <= 2'd0;
            r_frame_cnt <= 16'd0;
        end else if (flush) begin
            r_cnt <= 2'd0;
            r_idx <= 2'd0;
        end else begin
            if (w_in_hs)  r_cnt <= r_cnt + 2'd1;
            if (w_out_hs) r_idx <= r_idx + 2'd1;
            if (w_out_hs && (r_idx == 2'd3)) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Sample capture and result capture; results survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_x_r[k] <= {DATA_WIDTH{1'b0}};
                r_x_i[k] <= {DATA_WIDTH{1'b0}};
                r_y_r[k] <= {DATA_WIDTH{1'b0}};
                r_y_i[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_in_hs) begin
                r_x_r[r_cnt] <= in_r;
                r_x_i[r_cnt] <= in_i;
            end
            if ((r_state == ST_COMPUTE) && !flush) begin
                for (int k = 0; k < 4; k++) begin
                    r_y_r[k] <= w_y_r[k];
                    r_y_i[k] <= w_y_i[k];
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_UNLOAD);
    assign out_r     = r_y_r[r_idx];
    assign out_i     = r_y_i[r_idx];
    assign out_idx   = r_idx;
    assign out_last  = (r_state == ST_UNLOAD) && (r_idx == 2'd3);
    assign busy      = (r_state != ST_LOAD) || (r_cnt != 2'd0);
    assign frame_cnt = r_frame_cnt;
endmodule

// File: doc/fft_4_stream_ctrl.md
# fft_4_stream_ctrl

Streaming sequencer wrapped around one combinational `fft_4` core. It collects four complex samples over a valid/ready input stream and holds them in registers that drive the core. It captures the four core outputs one cycle later and returns them in natural order (y1..y4) over a valid/ready output stream. It is the unit the rest of the design uses to run framed 4-point FFTs without handling the combinational core directly.

## Interface
- `DATA_WIDTH`, default 64: width of each real/imag component, two's complement; passed to the `fft_4` instance.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort: discard the partial or pending frame and return to LOAD.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts an input sample.
- `in_r`, `in_i`  in  DATA_WIDTH each  input sample (real/imag).
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the output sample.
- `out_r`, `out_i`  out  DATA_WIDTH each  output sample.
- `out_idx`  out  2  output bin index (0 = y1 … 3 = y4).
- `out_last`  out  1  high with bin 3.
- `busy`  out  1  high whenever state ≠ LOAD or the load count ≠ 0.
- `frame_cnt`  out  16  number of completed frames; wraps modulo 2^16.

## Operation
- FSM states: LOAD, COMPUTE, UNLOAD. Reset state is LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid && in_ready`) writes sample register x[cnt] and increments the 2-bit `cnt`.
  - The handshake at cnt = 3 moves the FSM to COMPUTE and wraps `cnt` to 0.
- **COMPUTE** (exactly 1 cycle)
  - `in_ready` = 0.
  - The registered x1..x4 drive the `fft_4` core.
  - The core outputs y1..y4 are captured into four result registers.
  - Next state is UNLOAD with `idx` = 0.
- **UNLOAD**
  - `out_valid` = 1; `out_r`/`out_i` = result[idx]; `out_idx` = idx; `out_last` = (idx == 3).
  - Each handshake increments `idx`.
  - The handshake at idx = 3 increments `frame_cnt`, returns the FSM to LOAD and clears `idx`.
- **Arithmetic** is entirely inside `fft_4`; twiddle factors are integer (1, −j).
  - y1 = x1+x2+x3+x4
  - y2 = (x1−x3) − j(x2−x4)
  - y3 = x1−x2+x3−x4
  - y4 = (x1−x3) + j(x2−x4)
  - All sums wrap modulo 2^DATA_WIDTH. No scaling and no saturation.
- **Output stability:** while `out_valid && !out_ready`, `out_r`, `out_i`, `out_idx` and `out_last` are held stable.
- **flush**
  - In any state, it forces LOAD next cycle and clears `cnt` and `idx`.
  - `frame_cnt` is not incremented, and the result registers are not cleared.
  - An input handshake in the same cycle as `flush` is discarded.
  - An output handshake in the same cycle as `flush` counts as consumed downstream, but `frame_cnt` is still not incremented.
- **Backpressure:** `in_valid` outside LOAD is ignored (no handshake). `out_ready` outside UNLOAD is ignored.

## Timing
- **Reset values** (asynchronous on `rst_n` low): state LOAD, `cnt` 0, `idx` 0, x and result registers 0.
  - Outputs at reset: `in_ready` 1, `out_valid` 0, `out_r`/`out_i` 0, `out_idx` 0, `out_last` 0, `busy` 0, `frame_cnt` 0.
- `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `in_valid` or `out_ready`.
- **Latency:** the 4th input handshake on cycle N gives COMPUTE on N+1 and `out_valid` from N+2.
- **Throughput:** the minimum frame period is 9 cycles (4 LOAD + 1 COMPUTE + 4 UNLOAD) with both streams always ready.
- After the last output handshake on cycle M, `in_ready` = 1 on M+1.
- **Reset mid-frame:** all state clears immediately and no partial frame is emitted after release.
- `frame_cnt` updates in the cycle after the bin-3 handshake.

## Test plan
- **Impulse-free ramp:** inputs (1,0),(2,0),(3,0),(4,0) back-to-back, `out_ready`=1 → outputs (10,0),(−2,2),(−2,0),(−2,−2).
  - `out_idx` 0..3, `out_last` only on bin 3, `out_valid` first seen 2 cycles after the 4th input, `frame_cnt`=1.
- **Complex DC:** four inputs of (3,−5) → (12,−20),(0,0),(0,0),(0,0).
- **Backpressure:** same frame with `out_ready` toggling 0/1 each cycle → data held stable while stalled; `in_ready` stays 0 until 1 cycle after the bin-3 handshake.
- **Input gaps and wrap:**
  - `in_valid` with random gaps still captures exactly 4 samples.
  - Inputs (2^(DATA_WIDTH−1)−1, 0) ×4 → y1 real = −4 (wraps).
- **Flush:**
  - Flush after 2 input samples, then a full frame → only the full frame is emitted.
  - Flush during UNLOAD at idx=1 → `out_valid` drops next cycle, `frame_cnt` unchanged.
- **Reset mid-frame:** assert `rst_n`=0 during UNLOAD → all outputs immediately take their reset values; a fresh frame afterwards completes correctly.
